// File: rtl/y86_pkg.sv
// Y86-64 execute-stage shared constants: instruction codes, condition
// function codes, status codes and condition-code bit positions.
package y86_pkg;

   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] OPQ     = 4'h6;
   localparam logic [3:0] JXX     = 4'h7;

   localparam logic [3:0] C_YES = 4'h0;
   localparam logic [3:0] C_LE  = 4'h1;
   localparam logic [3:0] C_L   = 4'h2;
   localparam logic [3:0] C_E   = 4'h3;
   localparam logic [3:0] C_NE  = 4'h4;
   localparam logic [3:0] C_GE  = 4'h5;
   localparam logic [3:0] C_G   = 4'h6;

   localparam logic [3:0] STAT_AOK = 4'h1;
   localparam logic [3:0] STAT_HLT = 4'h2;
   localparam logic [3:0] STAT_ADR = 4'h3;
   localparam logic [3:0] STAT_INS = 4'h4;

   // Bit positions inside the packed {ZF,SF,OF} vector.
   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational Cnd evaluation for cmovXX / jXX from icode, ifun and {ZF,SF,OF}.
module cond_eval
   import y86_pkg::*;
(
   input  logic [3:0] icode,
   input  logic [3:0] ifun,
   input  logic [2:0] cc,
   output logic       cnd
);

   logic zf;
   logic lt;

   assign zf = cc[CC_ZF];
   assign lt = cc[CC_SF] ^ cc[CC_OF];

   always_comb begin
      cnd = 1'b0;
      if (icode == IRRMOVQ || icode == JXX) begin
         case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = lt | zf;
            C_L:     cnd = lt;
            C_E:     cnd = zf;
            C_NE:    cnd = ~zf;
            C_GE:    cnd = ~lt;
            C_G:     cnd = ~lt & ~zf;
            default: cnd = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/exec_cc_stage.sv
// Execute-stage back end: condition codes, Cnd evaluation and a one-entry output register.
// Optional EXEC_STAT_GATE_EN adds in_stat/out_stat and freezes CC after a non-AOK instruction.
module exec_cc_stage
   import y86_pkg::*;
#(
   parameter int         W      = 64,
   parameter logic [2:0] CC_RST = 3'b100
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   icode,
   input  logic [3:0]   ifun,
   input  logic [W-1:0] alu_out,
   input  logic         alu_ovf,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] valE,
   output logic         cnd,
`ifdef EXEC_STAT_GATE_EN
   input  logic [3:0]   in_stat,
   output logic [3:0]   out_stat,
`endif
   output logic [2:0]   cc_flags
);

   // Handshake: a beat moves on a rising edge when valid and ready are both
   // high; valid never depends on ready, and a held result stays stable until taken.
   logic         out_valid_q, out_valid_d;
   logic [W-1:0] vale_q, vale_d;
   logic         cnd_q, cnd_d;
   logic [2:0]   cc_q, cc_d;
   logic         accept;
   logic         cc_en;
   logic         cnd_w;

`ifdef EXEC_STAT_GATE_EN
   logic         halted_q, halted_d;
   logic [3:0]   stat_q, stat_d;
`endif

   assign in_ready = ~out_valid_q | out_ready;
   assign accept   = in_valid & in_ready;

   // Cnd sees the flags before this instruction's own update.
   cond_eval u_cond_eval (
      .icode (icode),
      .ifun  (ifun),
      .cc    (cc_q),
      .cnd   (cnd_w)
   );

`ifdef EXEC_STAT_GATE_EN
   assign cc_en = accept & (icode == OPQ) & ~halted_q & (in_stat == STAT_AOK);
`else
   assign cc_en = accept & (icode == OPQ);
`endif

   always_comb begin
      out_valid_d = out_valid_q;
      vale_d      = vale_q;
      cnd_d       = cnd_q;
      cc_d        = cc_q;
`ifdef EXEC_STAT_GATE_EN
      halted_d    = halted_q;
      stat_d      = stat_q;
`endif
      if (accept) begin
         out_valid_d = 1'b1;
         vale_d      = alu_out;
         cnd_d       = cnd_w;
`ifdef EXEC_STAT_GATE_EN
         stat_d      = in_stat;
         if (in_stat != STAT_AOK) halted_d = 1'b1;
`endif
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (cc_en) begin
         cc_d[CC_ZF] = (alu_out == '0);
         cc_d[CC_SF] = alu_out[W-1];
         cc_d[CC_OF] = alu_ovf;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         vale_q      <= '0;
         cnd_q       <= 1'b0;
         cc_q        <= CC_RST;
`ifdef EXEC_STAT_GATE_EN
         halted_q    <= 1'b0;
         stat_q      <= STAT_AOK;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         vale_q      <= vale_d;
         cnd_q       <= cnd_d;
         cc_q        <= cc_d;
`ifdef EXEC_STAT_GATE_EN
         halted_q    <= halted_d;
         stat_q      <= stat_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign valE      = vale_q;
   assign cnd       = cnd_q;
   assign cc_flags  = cc_q;
`ifdef EXEC_STAT_GATE_EN
   assign out_stat  = stat_q;
`endif

endmodule

// File: tb/tb_exec_cc_stage.sv
// Bench for exec_cc_stage: directed cases plus randomized traffic against a
// queue-based reference model. Honours EXEC_STAT_GATE_EN when defined.
module tb_exec_cc_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  icode = '0;
   logic [3:0]  ifun = '0;
   logic [63:0] alu_out = '0;
   logic        alu_ovf = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] valE;
   logic        cnd;
   logic [2:0]  cc_flags;
`ifdef EXEC_STAT_GATE_EN
   logic [3:0]  in_stat = 4'h1;
   logic [3:0]  out_stat;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Expected entries leaving the stage: {stat, cnd, valE}.
   logic [68:0] exp_q[$];
   logic [2:0]  m_cc = 3'b100;
   bit          m_halted = 1'b0;

   exec_cc_stage #(.W(64), .CC_RST(3'b100)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .icode     (icode),
      .ifun      (ifun),
      .alu_out   (alu_out),
      .alu_ovf   (alu_ovf),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .valE      (valE),
      .cnd       (cnd),
`ifdef EXEC_STAT_GATE_EN
      .in_stat   (in_stat),
      .out_stat  (out_stat),
`endif
      .cc_flags  (cc_flags)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Condition outcome straight from the Y86-64 condition definitions.
   function automatic bit model_cond(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] cc);
      bit zf, less;
      zf   = cc[2];
      less = (cc[1] != cc[0]);
      if (ic != 4'h2 && ic != 4'h7) return 1'b0;
      case (fn)
         4'd0:    return 1'b1;
         4'd1:    return less || zf;
         4'd2:    return less;
         4'd3:    return zf;
         4'd4:    return !zf;
         4'd5:    return !less;
         4'd6:    return !less && !zf;
         default: return 1'b0;
      endcase
   endfunction

   // One cycle: drive inputs after the falling edge, check outputs, then advance the model
   // to what the next rising edge should produce.
   task automatic drive(input bit iv, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] ao, input bit ovf, input bit ordy, input logic [3:0] st);
      bit       acc;
      bit       gate_ok;
      logic     ec;
      @(negedge clk);
      in_valid  = iv;
      icode     = ic;
      ifun      = fn;
      alu_out   = ao;
      alu_ovf   = ovf;
      out_ready = ordy;
`ifdef EXEC_STAT_GATE_EN
      in_stat   = st;
`endif
      #1;
      check_val("in_ready", in_ready, (exp_q.size() == 0) || ordy);
      check_val("out_valid", out_valid, exp_q.size() != 0);
      check_val("cc_flags", cc_flags, m_cc);
      if (exp_q.size() != 0) begin
         check_val("valE", valE, exp_q[0][63:0]);
         check_val("cnd", cnd, exp_q[0][64]);
`ifdef EXEC_STAT_GATE_EN
         check_val("out_stat", out_stat, exp_q[0][68:65]);
`endif
      end
      acc = iv && ((exp_q.size() == 0) || ordy);
      if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
      if (acc) begin
         ec = model_cond(ic, fn, m_cc);
         exp_q.push_back({st, ec, ao});
         gate_ok = 1'b1;
`ifdef EXEC_STAT_GATE_EN
         if (st != 4'h1) m_halted = 1'b1;
         gate_ok = !m_halted;
`endif
         if (ic == 4'h6 && gate_ok) m_cc = {ao == 64'd0, ao[63], ovf};
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 4'h0, 64'd0, 1'b0, 1'b1, 4'h1);
   endtask

   // Reset raised between edges must take effect immediately.
   task automatic apply_reset();
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check_val("rst_out_valid", out_valid, 1'b0);
      check_val("rst_cc_flags", cc_flags, 3'b100);
      check_val("rst_in_ready", in_ready, 1'b1);
      check_val("rst_valE", valE, 64'd0);
      check_val("rst_cnd", cnd, 1'b0);
`ifdef EXEC_STAT_GATE_EN
      check_val("rst_out_stat", out_stat, 4'h1);
`endif
      exp_q.delete();
      m_cc = 3'b100;
      m_halted = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [3:0]  ic_tab[5];
      logic [3:0]  r_ic, r_fn, r_st;
      logic [63:0] r_ao;

      ic_tab[0] = 4'h2; ic_tab[1] = 4'h3; ic_tab[2] = 4'h6; ic_tab[3] = 4'h7; ic_tab[4] = 4'h5;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idle(1);

      // Zero result sets ZF; je taken, jne not.
      drive(1'b1, 4'h6, 4'h0, 64'd0, 1'b0, 1'b1, 4'h1);
      drive(1'b1, 4'h7, 4'h3, 64'h100, 1'b0, 1'b1, 4'h1);
      check_val("zf_after_opq", cc_flags, 3'b100);
      drive(1'b1, 4'h7, 4'h4, 64'h104, 1'b0, 1'b1, 4'h1);
      check_val("je_taken", cnd, 1'b1);
      idle(1);
      check_val("jne_not_taken", cnd, 1'b0);

      // Negative overflowing result: SF=OF=1 so l false, ge true, ifun 7 false.
      drive(1'b1, 4'h6, 4'h1, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 4'h1);
      drive(1'b1, 4'h2, 4'h2, 64'h11, 1'b0, 1'b1, 4'h1);
      check_val("sf_of_set", cc_flags, 3'b011);
      drive(1'b1, 4'h2, 4'h5, 64'h22, 1'b0, 1'b1, 4'h1);
      check_val("cmovl", cnd, 1'b0);
      drive(1'b1, 4'h2, 4'h7, 64'h33, 1'b0, 1'b1, 4'h1);
      check_val("cmovge", cnd, 1'b1);
      idle(1);
      check_val("ifun7", cnd, 1'b0);

      // Non-OPq with zero result leaves CC alone.
      drive(1'b1, 4'h3, 4'h0, 64'd0, 1'b0, 1'b1, 4'h1);
      idle(1);
      check_val("non_opq_cc", cc_flags, 3'b011);
      check_val("non_opq_cnd", cnd, 1'b0);

      // Backpressure: three stalled cycles with a pending OPq.
      drive(1'b1, 4'h6, 4'h0, 64'h55, 1'b0, 1'b0, 4'h1);
      for (int i = 0; i < 3; i++) drive(1'b1, 4'h6, 4'h0, 64'd0, 1'b0, 1'b0, 4'h1);
      check_val("stall_valE", valE, 64'h55);
      check_val("stall_cc", cc_flags, 3'b000);
      drive(1'b1, 4'h6, 4'h0, 64'd0, 1'b0, 1'b1, 4'h1);
      idle(2);

      // Reset while a result is held.
      drive(1'b1, 4'h6, 4'h0, 64'h77, 1'b0, 1'b0, 4'h1);
      drive(1'b0, 4'h0, 4'h0, 64'd0, 1'b0, 1'b0, 4'h1);
      apply_reset();
      idle(1);

`ifdef EXEC_STAT_GATE_EN
      // A non-AOK instruction freezes CC from then on.
      drive(1'b1, 4'h6, 4'h0, 64'h8000_0000_0000_0001, 1'b0, 1'b1, 4'h3);
      drive(1'b1, 4'h6, 4'h0, 64'd0, 1'b0, 1'b1, 4'h1);
      check_val("stat_adr", out_stat, 4'h3);
      idle(1);
      check_val("stat_aok", out_stat, 4'h1);
      check_val("cc_frozen", cc_flags, 3'b100);
      apply_reset();
      idle(1);
`endif

      // Randomized traffic with random backpressure.
      for (int i = 0; i < 300; i++) begin
         r_ic = ic_tab[$urandom_range(0, 4)];
         r_fn = 4'($urandom_range(0, 8));
         case ($urandom_range(0, 3))
            0:       r_ao = 64'd0;
            1:       r_ao = {1'b1, 63'($urandom())};
            default: r_ao = {32'($urandom()), 32'($urandom())};
         endcase
         r_st = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
         drive($urandom_range(0, 3) != 0, r_ic, r_fn, r_ao, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3) != 0, r_st);
         if (i == 150) apply_reset();
      end
      idle(3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
